retire_trace_gen: RTL

- Producer side of the retirement trace interface.
- Sits at the end of the custom CPU pipeline and accepts one writeback/commit event per handshake from the WB stage.
- Buffers events in program order and emits them one per cycle on the 70-bit `inst_retire` bus, which the trace-compare bench samples.
- Also maintains a retired-instruction counter.

---
 rtl/retire_trace_gen.sv | 86 ++++++++
 1 files changed

// File: rtl/retire_trace_gen.sv
// Retirement trace producer: buffers WB commit events in order and emits one record per cycle on inst_retire.
// Latency: a push at edge t can appear after edge t+1 at the earliest. Backpressure: wb_ready drops while the FIFO is full.
module retire_trace_gen #(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             sys_clk,
    input  logic             sys_reset_n,
    input  logic             wb_valid,
    output logic             wb_ready,
    input  logic [31:0]      wb_pc,
    input  logic             wb_rf_wen,
    input  logic [4:0]       wb_rf_waddr,
    input  logic [31:0]      wb_rf_wdata,
    input  logic             drain_en,
    output logic [69:0]      inst_retire,
    output logic [31:0]      retire_cnt,
    output logic [PTR_W:0]   fifo_level
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] wdata;
        logic [4:0]  waddr;
        logic        wen;
    } entry_t;

    localparam logic [PTR_W:0] FULL_LVL = (PTR_W+1)'(DEPTH);

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [PTR_W:0]   r_level;
    logic [69:0]      r_retire;
    logic [31:0]      r_cnt;

    logic   w_full;
    logic   w_push;
    logic   w_pop;
    entry_t w_head;

    // Ready depends only on registered occupancy, so a full FIFO refuses a push even when popping.
    assign w_full   = (r_level == FULL_LVL);
    assign wb_ready = sys_reset_n & ~w_full;
    assign w_push   = wb_valid & wb_ready;
    assign w_pop    = drain_en & (r_level != '0);
    assign w_head   = r_mem[r_rptr];

    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= '{pc: wb_pc, wdata: wb_rf_wdata, waddr: wb_rf_waddr, wen: wb_rf_wen};
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_reset_n) begin
            r_wptr   <= '0;
            r_rptr   <= '0;
            r_level  <= '0;
            r_retire <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr   <= r_rptr + PTR_W'(1);
                r_cnt    <= r_cnt + 32'd1;
                // Writes to x0 are architecturally invisible, so they retire without the rf_en qualifier.
                r_retire <= {w_head.wen & (w_head.waddr != 5'd0), w_head.waddr, w_head.wdata, w_head.pc};
            end else begin
                r_retire[69] <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + (PTR_W+1)'(1);
                2'b01:   r_level <= r_level - (PTR_W+1)'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign inst_retire = r_retire;
    assign retire_cnt  = r_cnt;
    assign fifo_level  = r_level;

endmodule
